// File: rtl/sram_tp_reg_based_multi_bank_clr_pkg.sv
// Shared definitions for the multi-bank two-port register SRAM with clear sequencer:
// clear FSM encodings and the ceiling-log2 helper used to size indices.
package sram_tp_reg_based_multi_bank_clr_pkg;

    localparam int CLR_ST_WD = 2;

    localparam logic [CLR_ST_WD-1:0] CLR_IDLE = 2'd0;
    localparam logic [CLR_ST_WD-1:0] CLR_CLR  = 2'd1;
    localparam logic [CLR_ST_WD-1:0] CLR_DONE = 2'd2;

    // Ceiling log2 with a floor of 1 bit, so a 2-entry index still gets a wire.
    function automatic int func_log2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_tp_reg_based_multi_bank_clr_bank.sv
// One register-array bank: synchronous write, read data captured on the read strobe,
// optional same-cycle write-to-read bypass. Storage is deliberately left unreset.
module sram_tp_reg_based_multi_bank_clr_bank
    import sram_tp_reg_based_multi_bank_clr_pkg::*;
#(
    parameter int KNOB_BYPASS = 0,
    parameter int SIZE        = 8,
    parameter int SIZE_WD     = 3,
    parameter int DATA_WD     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [SIZE_WD-1:0] wr_adr,
    input  logic [DATA_WD-1:0] wr_dat,
    input  logic               rd_en,
    input  logic [SIZE_WD-1:0] rd_adr,
    output logic [DATA_WD-1:0] rd_dat
);

    logic [DATA_WD-1:0] mem_r [SIZE];
    logic [DATA_WD-1:0] rd_dat_r;
    logic [DATA_WD-1:0] rd_nxt_s;

    // storage write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_adr] <= wr_dat;
        end
    end

    // read source select, forwarding the in-flight write when bypass is enabled
    always_comb begin
        rd_nxt_s = mem_r[rd_adr];
        if ((KNOB_BYPASS == 1) && wr_en && (wr_adr == rd_adr)) begin
            rd_nxt_s = wr_dat;
        end else begin
            rd_nxt_s = mem_r[rd_adr];
        end
    end

    // read data register, holds between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dat_r <= {DATA_WD{1'b0}};
        end else if (rd_en) begin
            rd_dat_r <= rd_nxt_s;
        end
    end

    assign rd_dat = rd_dat_r;

endmodule

// File: rtl/sram_tp_reg_based_multi_bank_clr.sv
// Multi-bank two-port register SRAM with independent write/read bank selects and a
// hardware sequencer that zeroes one bank or all banks.
module sram_tp_reg_based_multi_bank_clr
    import sram_tp_reg_based_multi_bank_clr_pkg::*;
#(
    parameter int  KNOB_REGOUT = 0,
    parameter int  KNOB_BYPASS = 0,
    parameter int  NUMB_BNK    = 3,
    parameter int  SIZE        = 8,
    parameter int  DATA_WD     = 8,
    localparam int NUMB_BNK_WD = func_log2(NUMB_BNK),
    localparam int SIZE_WD     = func_log2(SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUMB_BNK_WD-1:0] wr_bnk_i,
    input  logic                   wr_val_i,
    input  logic [SIZE_WD-1:0]     wr_adr_i,
    input  logic [DATA_WD-1:0]     wr_dat_i,
    input  logic [NUMB_BNK_WD-1:0] rd_bnk_i,
    input  logic                   rd_val_i,
    input  logic [SIZE_WD-1:0]     rd_adr_i,
    output logic                   rd_val_o,
    output logic [DATA_WD-1:0]     rd_dat_o,
    input  logic                   clr_req_i,
    input  logic                   clr_all_i,
    input  logic [NUMB_BNK_WD-1:0] clr_bnk_i,
    output logic                   clr_bsy_o,
    output logic                   clr_don_o
);

    localparam logic [SIZE_WD-1:0]   CNT_LAST = SIZE_WD'(SIZE - 1);
    localparam logic [NUMB_BNK_WD:0] BNK_LIM  = (NUMB_BNK_WD + 1)'(NUMB_BNK);

    if ((KNOB_REGOUT != 0) && (KNOB_REGOUT != 1)) begin : g_bad_regout
        $error("sram_tp_reg_based_multi_bank_clr: KNOB_REGOUT must be 0 or 1");
    end

    logic [CLR_ST_WD-1:0]   clr_st_r;
    logic [CLR_ST_WD-1:0]   clr_st_nxt_s;
    logic [SIZE_WD-1:0]     clr_cnt_r;
    logic                   clr_all_r;
    logic [NUMB_BNK_WD-1:0] clr_bnk_r;
    logic                   clr_bsy_r;
    logic                   clr_don_r;

    // clear sequencer next state; requests outside IDLE are dropped
    always_comb begin
        clr_st_nxt_s = clr_st_r;
        case (clr_st_r)
            CLR_IDLE: begin
                if (clr_req_i) begin
                    clr_st_nxt_s = CLR_CLR;
                end else begin
                    clr_st_nxt_s = CLR_IDLE;
                end
            end
            CLR_CLR: begin
                if (clr_cnt_r == CNT_LAST) begin
                    clr_st_nxt_s = CLR_DONE;
                end else begin
                    clr_st_nxt_s = CLR_CLR;
                end
            end
            CLR_DONE: clr_st_nxt_s = CLR_IDLE;
            default:  clr_st_nxt_s = CLR_IDLE;
        endcase
    end

    // clear state, latched target and counter; busy/done are registered off the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_st_r  <= CLR_IDLE;
            clr_cnt_r <= {SIZE_WD{1'b0}};
            clr_all_r <= 1'b0;
            clr_bnk_r <= {NUMB_BNK_WD{1'b0}};
            clr_bsy_r <= 1'b0;
            clr_don_r <= 1'b0;
        end else begin
            clr_st_r  <= clr_st_nxt_s;
            clr_bsy_r <= (clr_st_nxt_s == CLR_CLR);
            clr_don_r <= (clr_st_nxt_s == CLR_DONE);
            if ((clr_st_r == CLR_IDLE) && clr_req_i) begin
                clr_all_r <= clr_all_i;
                clr_bnk_r <= clr_bnk_i;
                clr_cnt_r <= {SIZE_WD{1'b0}};
            end else if ((clr_st_r == CLR_CLR) && (clr_cnt_r != CNT_LAST)) begin
                clr_cnt_r <= clr_cnt_r + SIZE_WD'(1);
            end
        end
    end

    assign clr_bsy_o = clr_bsy_r;
    assign clr_don_o = clr_don_r;

    logic [DATA_WD-1:0] bnk_rdat_s [NUMB_BNK];

    for (genvar b = 0; b < NUMB_BNK; b++) begin : g_bnk
        logic               tgt_s;
        logic               wen_s;
        logic               ren_s;
        logic [SIZE_WD-1:0] wadr_s;
        logic [DATA_WD-1:0] wdat_s;

        // a bank under clear is owned by the sequencer; reset suppresses the pending clear write
        always_comb begin
            tgt_s = (clr_st_r == CLR_CLR) && (clr_all_r || (clr_bnk_r == NUMB_BNK_WD'(b)));
            wen_s = (tgt_s && !rst) || (wr_val_i && (wr_bnk_i == NUMB_BNK_WD'(b)) && !tgt_s);
            ren_s = rd_val_i && (rd_bnk_i == NUMB_BNK_WD'(b));
            if (tgt_s) begin
                wadr_s = clr_cnt_r;
                wdat_s = {DATA_WD{1'b0}};
            end else begin
                wadr_s = wr_adr_i;
                wdat_s = wr_dat_i;
            end
        end

        sram_tp_reg_based_multi_bank_clr_bank #(
            .KNOB_BYPASS (KNOB_BYPASS),
            .SIZE        (SIZE),
            .SIZE_WD     (SIZE_WD),
            .DATA_WD     (DATA_WD)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wen_s),
            .wr_adr (wadr_s),
            .wr_dat (wdat_s),
            .rd_en  (ren_s),
            .rd_adr (rd_adr_i),
            .rd_dat (bnk_rdat_s[b])
        );
    end

    logic                   rd_val_r;
    logic                   rd_oor_r;
    logic [NUMB_BNK_WD-1:0] rd_sel_r;
    logic [DATA_WD-1:0]     rd_mux_s;

    // remember which bank answered the last read so the returned word holds
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_val_r <= 1'b0;
            rd_oor_r <= 1'b0;
            rd_sel_r <= {NUMB_BNK_WD{1'b0}};
        end else begin
            rd_val_r <= rd_val_i;
            if (rd_val_i) begin
                rd_sel_r <= rd_bnk_i;
                rd_oor_r <= ({1'b0, rd_bnk_i} >= BNK_LIM);
            end
        end
    end

    // read mux; an out-of-range bank returns zero
    always_comb begin
        rd_mux_s = {DATA_WD{1'b0}};
        for (int b = 0; b < NUMB_BNK; b++) begin
            if (!rd_oor_r && (rd_sel_r == NUMB_BNK_WD'(b))) begin
                rd_mux_s = bnk_rdat_s[b];
            end else begin
                rd_mux_s = rd_mux_s;
            end
        end
    end

    if (KNOB_REGOUT == 1) begin : g_regout
        logic               rd_val_q_r;
        logic [DATA_WD-1:0] rd_dat_q_r;

        // extra output stage
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_val_q_r <= 1'b0;
                rd_dat_q_r <= {DATA_WD{1'b0}};
            end else begin
                rd_val_q_r <= rd_val_r;
                if (rd_val_r) begin
                    rd_dat_q_r <= rd_mux_s;
                end
            end
        end

        assign rd_val_o = rd_val_q_r;
        assign rd_dat_o = rd_dat_q_r;
    end else begin : g_direct
        assign rd_val_o = rd_val_r;
        assign rd_dat_o = rd_mux_s;
    end

endmodule

// File: tb/tb_sram_tp_reg_based_multi_bank_clr.sv
// Bench: two DUT flavours (no regout/no bypass, regout/bypass) on shared stimulus,
// checked against an array-based model of storage, read latency and the clear timeline.
module tb_sram_tp_reg_based_multi_bank_clr;
    import sram_tp_reg_based_multi_bank_clr_pkg::*;

    localparam int NB = 3;
    localparam int SZ = 8;
    localparam int DW = 8;
    localparam int BW = func_log2(NB);
    localparam int AW = func_log2(SZ);

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] wr_bnk, rd_bnk, clr_bnk;
    logic          wr_val, rd_val, clr_req, clr_all;
    logic [AW-1:0] wr_adr, rd_adr;
    logic [DW-1:0] wr_dat;
    logic          rv0, rv1, bsy0, bsy1, don0, don1;
    logic [DW-1:0] rd0, rd1;

    always #5 clk = ~clk;

    sram_tp_reg_based_multi_bank_clr #(
        .KNOB_REGOUT(0), .KNOB_BYPASS(0), .NUMB_BNK(NB), .SIZE(SZ), .DATA_WD(DW)
    ) dut0 (
        .clk(clk), .rst(rst),
        .wr_bnk_i(wr_bnk), .wr_val_i(wr_val), .wr_adr_i(wr_adr), .wr_dat_i(wr_dat),
        .rd_bnk_i(rd_bnk), .rd_val_i(rd_val), .rd_adr_i(rd_adr),
        .rd_val_o(rv0), .rd_dat_o(rd0),
        .clr_req_i(clr_req), .clr_all_i(clr_all), .clr_bnk_i(clr_bnk),
        .clr_bsy_o(bsy0), .clr_don_o(don0)
    );

    sram_tp_reg_based_multi_bank_clr #(
        .KNOB_REGOUT(1), .KNOB_BYPASS(1), .NUMB_BNK(NB), .SIZE(SZ), .DATA_WD(DW)
    ) dut1 (
        .clk(clk), .rst(rst),
        .wr_bnk_i(wr_bnk), .wr_val_i(wr_val), .wr_adr_i(wr_adr), .wr_dat_i(wr_dat),
        .rd_bnk_i(rd_bnk), .rd_val_i(rd_val), .rd_adr_i(rd_adr),
        .rd_val_o(rv1), .rd_dat_o(rd1),
        .clr_req_i(clr_req), .clr_all_i(clr_all), .clr_bnk_i(clr_bnk),
        .clr_bsy_o(bsy1), .clr_don_o(don1)
    );

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [DW-1:0] m_mem [NB][SZ];
    logic          m_v1 = 1'b0, m_v2 = 1'b0;
    logic [DW-1:0] m_d1a = 8'h00, m_d1b = 8'h00, m_d2 = 8'h00;
    int            m_clr_addr = -1;
    bit            m_clr_all = 1'b0;
    int            m_clr_bnk = 0;
    bit            m_don = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // apply the effect of the coming clock edge to the model, using the current inputs
    task automatic model_edge();
        logic [DW-1:0] old_v, new_v;
        bit clearing, usr_ok, was_don;
        int ca;
        ca       = m_clr_addr;
        was_don  = m_don;
        clearing = (ca >= 0) && !rst;
        usr_ok   = wr_val && (int'(wr_bnk) < NB) &&
                   !((ca >= 0) && (m_clr_all || (m_clr_bnk == int'(wr_bnk))));
        old_v = 8'h00;
        new_v = 8'h00;
        if (rd_val && (int'(rd_bnk) < NB)) begin
            old_v = m_mem[rd_bnk][rd_adr];
            new_v = old_v;
            if (clearing && (m_clr_all || (m_clr_bnk == int'(rd_bnk))) && (ca == int'(rd_adr)))
                new_v = 8'h00;
            else if (usr_ok && (wr_bnk == rd_bnk) && (wr_adr == rd_adr))
                new_v = wr_dat;
        end
        if (rst) begin
            m_v1 = 1'b0; m_d1a = 8'h00; m_d1b = 8'h00; m_v2 = 1'b0; m_d2 = 8'h00;
        end else begin
            if (m_v1) m_d2 = m_d1b;
            m_v2 = m_v1;
            m_v1 = rd_val;
            if (rd_val) begin
                m_d1a = old_v;
                m_d1b = new_v;
            end
        end
        if (clearing)
            for (int b = 0; b < NB; b++)
                if (m_clr_all || (m_clr_bnk == b)) m_mem[b][ca] = 8'h00;
        if (usr_ok) m_mem[wr_bnk][wr_adr] = wr_dat;
        if (rst) begin
            m_clr_addr = -1;
            m_don      = 1'b0;
        end else begin
            m_don = (ca == SZ - 1);
            if (ca >= 0) begin
                m_clr_addr = (ca == SZ - 1) ? -1 : ca + 1;
            end else if (clr_req && !was_don) begin
                m_clr_addr = 0;
                m_clr_all  = clr_all;
                m_clr_bnk  = int'(clr_bnk);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_val("rd_val_o/regout0", {31'd0, rv0}, {31'd0, m_v1});
        check_val("rd_dat_o/regout0", {24'd0, rd0}, {24'd0, m_d1a});
        check_val("rd_val_o/regout1", {31'd0, rv1}, {31'd0, m_v2});
        check_val("rd_dat_o/regout1", {24'd0, rd1}, {24'd0, m_d2});
        check_val("clr_bsy_o/dut0", {31'd0, bsy0}, {31'd0, (m_clr_addr >= 0)});
        check_val("clr_bsy_o/dut1", {31'd0, bsy1}, {31'd0, (m_clr_addr >= 0)});
        check_val("clr_don_o/dut0", {31'd0, don0}, {31'd0, m_don});
        check_val("clr_don_o/dut1", {31'd0, don1}, {31'd0, m_don});
    endtask

    task automatic cyc(input bit wv, input int wb, input int wa, input int wd,
                       input bit rv, input int rb, input int ra);
        wr_val = wv; wr_bnk = BW'(wb); wr_adr = AW'(wa); wr_dat = DW'(wd);
        rd_val = rv; rd_bnk = BW'(rb); rd_adr = AW'(ra);
        step();
    endtask

    task automatic fill_all(input int d);
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < SZ; a++)
                cyc(1'b1, b, a, d, 1'b0, 0, 0);
    endtask

    initial begin
        int n_bsy;
        rst = 1'b1; clr_req = 1'b0; clr_all = 1'b0; clr_bnk = '0;
        cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
        cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
        check_val("reset_rd_dat", {24'd0, rd1}, 32'd0);
        rst = 1'b0;
        fill_all(8'hFF);

        // basic access and read latency
        cyc(1'b1, 1, 3, 8'hA5, 1'b0, 0, 0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1, 3);
        check_val("basic_val0", {31'd0, rv0}, 32'd1);
        check_val("basic_dat0", {24'd0, rd0}, 32'hA5);
        cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
        check_val("basic_val1", {31'd0, rv1}, 32'd1);
        check_val("basic_dat1", {24'd0, rd1}, 32'hA5);

        // independent selects
        cyc(1'b1, 2, 0, 8'h22, 1'b0, 0, 0);
        cyc(1'b1, 0, 0, 8'h11, 1'b1, 2, 0);
        check_val("indep_rd", {24'd0, rd0}, 32'h22);
        cyc(1'b0, 0, 0, 0, 1'b1, 0, 0);
        check_val("indep_wr", {24'd0, rd0}, 32'h11);

        // same-cycle collision
        cyc(1'b1, 1, 5, 8'h3C, 1'b0, 0, 0);
        cyc(1'b1, 1, 5, 8'h5A, 1'b1, 1, 5);
        check_val("collide_nobyp", {24'd0, rd0}, 32'h3C);
        cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
        check_val("collide_byp", {24'd0, rd1}, 32'h5A);

        // clear one bank, with a user write to it in the middle
        fill_all(8'hFF);
        clr_req = 1'b1; clr_bnk = BW'(2);
        cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
        clr_req = 1'b0;
        n_bsy = bsy0 ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            cyc((i == 2), 2, 5, 8'h77, 1'b0, 0, 0);
            if (bsy0) n_bsy++;
        end
        check_val("clr1_bsy_len", n_bsy, 32'd8);
        check_val("clr1_done", {31'd0, don0}, 32'd1);
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < SZ; a++) begin
                cyc(1'b0, 0, 0, 0, 1'b1, b, a);
                check_val("clr1_content", {24'd0, rd0}, (b == 2) ? 32'h00 : 32'hFF);
            end

        // clear all, second request mid-sequence must be ignored
        clr_req = 1'b1; clr_all = 1'b1;
        cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
        clr_req = 1'b0; clr_all = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
        clr_req = 1'b1; clr_bnk = BW'(1);
        cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
        clr_req = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
        check_val("clr_all_idle", {31'd0, bsy0}, 32'd0);
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < SZ; a++) begin
                cyc(1'b0, 0, 0, 0, 1'b1, b, a);
                check_val("clr_all_content", {24'd0, rd0}, 32'h00);
            end

        // reset in the fourth cycle of a clear
        for (int a = 0; a < SZ; a++) cyc(1'b1, 1, a, 8'hFF, 1'b0, 0, 0);
        clr_req = 1'b1; clr_bnk = BW'(1);
        cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
        clr_req = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
        rst = 1'b1;
        cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
        rst = 1'b0;
        check_val("rstclr_bsy", {31'd0, bsy0}, 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
        for (int a = 0; a < SZ; a++) begin
            cyc(1'b0, 0, 0, 0, 1'b1, 1, a);
            check_val("rstclr_content", {24'd0, rd0}, (a < 3) ? 32'h00 : 32'hFF);
        end

        // randomized traffic, including out-of-range banks, clears and resets
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(299) == 0);
            clr_req = ($urandom_range(39) == 0);
            clr_all = $urandom_range(1);
            clr_bnk = BW'($urandom_range(3));
            cyc($urandom_range(1), $urandom_range(3), $urandom_range(SZ - 1), $urandom_range(255),
                $urandom_range(1), $urandom_range(3), $urandom_range(SZ - 1));
        end
        rst = 1'b0; clr_req = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_tp_reg_based_multi_bank_clr.md
# sram_tp_reg_based_multi_bank_clr

Register-based two-port SRAM split into NUMB_BNK banks, with independent write-bank and read-bank selects, an optional write-to-read bypass, and a hardware clear sequencer that zeroes one bank or all banks. It is the successor to the single-select multi-bank SRAM. Ping-pong and line buffers use it to fill one bank while draining another, then wipe a bank between frames without a software loop.

## Interface
Parameters:
- KNOB_REGOUT, -1, 0: read data unregistered at output; 1: extra output register. Any other value is illegal and the sim sanity check fires.
- KNOB_BYPASS, 0, 1: a same-cycle read of the bank/address being written returns the new data.
- NUMB_BNK, -1, number of banks, ≥2.
- SIZE, -1, words per bank, ≥2.
- DATA_WD, -1, word width.
- NUMB_BNK_WD, local, `FUNC_LOG2(NUMB_BNK)`.
- SIZE_WD, local, `FUNC_LOG2(SIZE)`.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_bnk_i  in  NUMB_BNK_WD  write bank index
- wr_val_i  in  1  write strobe
- wr_adr_i  in  SIZE_WD  write address
- wr_dat_i  in  DATA_WD  write data
- rd_bnk_i  in  NUMB_BNK_WD  read bank index
- rd_val_i  in  1  read strobe
- rd_adr_i  in  SIZE_WD  read address
- rd_val_o  out  1  read data valid
- rd_dat_o  out  DATA_WD  read data
- clr_req_i  in  1  clear request, single-cycle pulse
- clr_all_i  in  1  sampled with clr_req_i; 1 clears all banks
- clr_bnk_i  in  NUMB_BNK_WD  sampled with clr_req_i; bank to clear
- clr_bsy_o  out  1  clear in progress
- clr_don_o  out  1  one-cycle completion pulse

## Operation
- **Writes:** a write lands in bank wr_bnk_i at wr_adr_i when wr_val_i=1.
- **Reads:** a read samples bank rd_bnk_i at rd_adr_i when rd_val_i=1.
- **Independent selects:** the write and read bank selects are independent, so a simultaneous write to bank A and read from bank B is legal.
- **Out-of-range bank index** (≥NUMB_BNK): the write is dropped, or the read returns 0. rd_val_o still asserts for the read.
- **Clear FSM states:** IDLE, CLR, DONE.
- **IDLE→CLR:** on clr_req_i. The block latches clr_all_i and clr_bnk_i and zeroes the address counter.
- **CLR:**
  - Writes 0 to address cnt of the target bank, or of every bank when clr_all_i was latched.
  - cnt increments each cycle; when cnt==SIZE-1 the FSM goes to DONE.
- **DONE:** clr_don_o=1 for one cycle, then IDLE.
- **clr_req_i outside IDLE:** ignored and not queued.
- **User writes during CLR:** a user write to a bank being cleared is dropped. Writes to other banks proceed.
- **User reads during CLR:** unaffected. They return the current content, old or zeroed.
- **Bypass:** a clear write counts as a write of 0 for the bypass rule.
- **Storage reset:** storage is not reset; only control state and outputs are.
- **Reset mid-clear:** the FSM returns to IDLE with no done pulse, and the bank is left partially cleared.

## Timing
- **Reset values:** rd_val_o=0, rd_dat_o=0, clr_bsy_o=0, clr_don_o=0.
- **Read latency:** rd_val_o rises 1 cycle after rd_val_i when KNOB_REGOUT=0, and 2 cycles after when KNOB_REGOUT=1.
- **Data hold:** rd_dat_o holds the last returned word until the next valid return.
- **Write timing:** a write at cycle t is visible to a read issued at t+1.
- **Same-cycle collision** (same bank, same address):
  - KNOB_BYPASS=1 returns the new data.
  - KNOB_BYPASS=0 returns the old data.
- **Clear sequence** (clr_req_i at cycle t):
  - clr_bsy_o=1 for cycles t+1 … t+SIZE.
  - Address k is zeroed at the end of cycle t+1+k.
  - clr_don_o=1 at cycle t+SIZE+1, with clr_bsy_o=0 in that cycle.
  - The earliest new accepted request is at t+SIZE+2.
- **Clear counter:** width SIZE_WD. It must not wrap before the transition to DONE, including for non-power-of-2 SIZE.

## Structure
- **Shared package (define.vh):**
  - `FUNC_LOG2`.
  - Clear FSM state encodings: CLR_IDLE=0, CLR_CLR=1, CLR_DONE=2, with a 2-bit state width.
- **Sub-module sram_tp_reg_bank:**
  - Holds one bank: register array, synchronous write, read data registered on the read strobe, same-cycle bypass mux.
  - Generated NUMB_BNK times.
- **Top level:** bank decode, clear FSM/counter, write arbitration (clear over user), read mux, and the output register.

## Test plan
- Power-on reset → all outputs 0.
- Basic access: KNOB_REGOUT=0, write 0xA5 to bank1/adr3, then read bank1/adr3 at the next cycle → rd_val_o and 0xA5 one cycle after the read strobe. With KNOB_REGOUT=1 → same data after two cycles.
- Independent selects: write bank0/adr0=0x11 while reading bank2/adr0=0x22 in the same cycle → read returns 0x22 and bank0/adr0 holds 0x11.
- Collision: same bank/address write 0x5A over old 0x3C with a same-cycle read → KNOB_BYPASS=1 returns 0x5A, KNOB_BYPASS=0 returns 0x3C.
- Clear one bank: SIZE=8, fill all banks with 0xFF, clr_req_i with clr_bnk_i=2 → clr_bsy_o high for 8 cycles, then a one-cycle clr_don_o. Bank 2 reads 0 at every address, other banks read 0xFF. A user write to bank2 during the clear is dropped.
- Clear with interruptions: clr_all_i=1 with a second clr_req_i during the clear → second request ignored, all banks read 0 afterwards. rst asserted at cycle 4 of a clear → clr_bsy_o=0 next cycle, no clr_don_o, and addresses ≥3 keep their old data.
